// File: rtl/alsu_result_tx.sv
// alsu_result_tx: one-entry buffered serial transmitter for ALSU results.
// Frame: start, 6 data bits LSB first, flag, [even parity when ALSU_TX_PARITY_EN is defined], stop.
module alsu_result_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  invalid_count,
    output logic [7:0]  drop_count
);

    localparam logic [7:0] LAST_CYCLE = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        FLAG,
        PARITY,
        STOP
    } state_t;

    state_t     state;
    logic       hold_valid;
    logic [6:0] hold_data;
    logic [5:0] shift_reg;
    logic       flag_reg;
`ifdef ALSU_TX_PARITY_EN
    logic       parity_reg;
`endif
    logic [7:0] cycle_cnt;
    logic [2:0] bit_cnt;

    logic bit_last;
    logic load;
    logic accept;
    logic refuse;

    assign in_ready = ~hold_valid;
    assign accept   = in_valid & ~hold_valid;
    assign refuse   = in_valid & hold_valid;
    assign bit_last = (cycle_cnt == LAST_CYCLE);
    // The buffer drains into the shifter either from idle or on the last stop cycle.
    assign load     = hold_valid & ((state == IDLE) | ((state == STOP) & bit_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_data  <= {|alsu_leds, alsu_out};
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            invalid_count <= '0;
            drop_count    <= '0;
        end else begin
            if (accept && (|alsu_leds) && (invalid_count != 8'hFF)) begin
                invalid_count <= invalid_count + 8'd1;
            end
            if (refuse && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cycle_cnt  <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            flag_reg   <= 1'b0;
`ifdef ALSU_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (load) begin
                shift_reg  <= hold_data[5:0];
                flag_reg   <= hold_data[6];
`ifdef ALSU_TX_PARITY_EN
                parity_reg <= ^hold_data;
`endif
            end
            case (state)
                IDLE: begin
                    if (hold_valid) begin
                        state     <= START;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        cycle_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_last) begin
                        state     <= DATA;
                        cycle_cnt <= '0;
                        bit_cnt   <= '0;
                        tx        <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[5:1]};
                    end else begin
                        cycle_cnt <= cycle_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        cycle_cnt <= '0;
                        if (bit_cnt == 3'd5) begin
                            state <= FLAG;
                            tx    <= flag_reg;
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            tx        <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[5:1]};
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 8'd1;
                    end
                end
                FLAG: begin
                    if (bit_last) begin
                        cycle_cnt <= '0;
`ifdef ALSU_TX_PARITY_EN
                        state     <= PARITY;
                        tx        <= parity_reg;
`else
                        state      <= STOP;
                        tx         <= 1'b1;
                        frame_done <= (LAST_CYCLE == 8'd0);
`endif
                    end else begin
                        cycle_cnt <= cycle_cnt + 8'd1;
                    end
                end
`ifdef ALSU_TX_PARITY_EN
                PARITY: begin
                    if (bit_last) begin
                        cycle_cnt  <= '0;
                        state      <= STOP;
                        tx         <= 1'b1;
                        frame_done <= (LAST_CYCLE == 8'd0);
                    end else begin
                        cycle_cnt <= cycle_cnt + 8'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_last) begin
                        cycle_cnt <= '0;
                        if (hold_valid) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cycle_cnt  <= cycle_cnt + 8'd1;
                        // Pulse lands on the final stop cycle, registered one edge early.
                        frame_done <= ((cycle_cnt + 8'd1) == LAST_CYCLE);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_result_tx.sv
// Scoreboard bench for alsu_result_tx: stimulus queues expected frames, a negedge monitor checks tx bit by bit.
`timescale 1ns/1ps
module tb_alsu_result_tx;
`ifdef ALSU_TX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  alsu_out = '0;
    logic [15:0] alsu_leds = '0;
    logic        tx, busy, frame_done;
    logic [7:0]  invalid_count, drop_count;

    typedef struct {
        logic [5:0] data;
        logic       flag;
        logic       parity;
        bit         b2b;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   in_frame = 0;
    exp_t cur;
    int   bi = 0;
    int   ci = 0;
    int   end_cyc = -100;

    alsu_result_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds), .tx(tx), .busy(busy),
        .frame_done(frame_done), .invalid_count(invalid_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] d, input logic f, input logic p, input bit b);
        exp_t e;
        e.data = d; e.flag = f; e.parity = p; e.b2b = b;
        return e;
    endfunction

    function automatic logic exp_bit(input exp_t e, input int b);
        if (b == 0) return 1'b0;
        if (b <= 6) return e.data[b-1];
        if (b == 7) return e.flag;
        if (b == 8 && NBITS == 10) return e.parity;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 0;
            check("frame_done_in_reset", frame_done, 0);
        end else begin
            if (!in_frame && tx == 1'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_start", tx, 1);
                end else begin
                    cur = sb.pop_front();
                    in_frame = 1; bi = 0; ci = 0;
                    if (cur.b2b) check("b2b_gap", cyc - end_cyc, 1);
                end
            end
            if (in_frame) begin
                check($sformatf("tx_bit%0d_cyc%0d", bi, ci), tx, exp_bit(cur, bi));
                check($sformatf("frame_done_bit%0d_cyc%0d", bi, ci), frame_done,
                      (bi == NBITS - 1 && ci == CPB - 1));
                ci++;
                if (ci == CPB) begin
                    ci = 0; bi++;
                    if (bi == NBITS) begin
                        in_frame = 0;
                        end_cyc = cyc;
                        $display("[TB] frame data=%b flag=%b done at cycle %0d", cur.data, cur.flag, cyc);
                    end
                end
            end else begin
                check("idle_frame_done", frame_done, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Offers one result and keeps in_valid high until it is accepted.
    task automatic offer(input logic [5:0] d, input logic [15:0] l, input exp_t e, input bit push);
        bit rdy;
        int n = 0;
        alsu_out = d; alsu_leds = l; in_valid = 1'b1;
        do begin
            rdy = in_ready;
            step();
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check("offer_timeout", in_ready, 1);
        else if (push) sb.push_back(e);
        $display("[TB] offer out=%b leds=%h accepted=%0d after %0d cycles", d, l, rdy, n);
    endtask

    task automatic scramble();
        in_valid = 1'b0; alsu_out = 6'h2A; alsu_leds = 16'h8000;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || in_frame || sb.size() != 0 || !in_ready) && n < 3000) begin
            step();
            n++;
        end
        check(name, (n < 3000), 1);
    endtask

    exp_t ea, eb, ec, ed, ee;

    initial begin
        int n;
        int acc;
        bit rdy;
        ea = mk(6'b101101, 1'b0, 1'b0, 1'b0);
        eb = mk(6'b000001, 1'b1, 1'b0, 1'b0);
        ec = mk(6'b110010, 1'b0, 1'b1, 1'b0);
        ed = mk(6'b011100, 1'b1, 1'b0, 1'b1);
        ee = mk(6'b111111, 1'b0, 1'b0, 1'b1);

        #1 rst = 1'b1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_invalid_count", invalid_count, 0);
        check("rst_drop_count", drop_count, 0);
        repeat (3) step();
        rst = 1'b0;
        step();
        check("idle_tx", tx, 1);

        // Single valid result: frame_done timing measured from the acceptance edge.
        offer(6'b101101, 16'h0000, ea, 1);
        scramble();
        n = 0;
        while (!frame_done && n < 100) begin step(); n++; end
        check("frame_done_cycle", n, NBITS * CPB);
        wait_idle("idle_after_a");
        check("invalid_after_a", invalid_count, 0);

        // Invalid result: flag set, counter increments at acceptance.
        offer(6'b000001, 16'hFFFF, eb, 1);
        scramble();
        check("invalid_after_b", invalid_count, 1);
        wait_idle("idle_after_b");

        // Three results back to back with in_valid held high throughout.
        offer(6'b110010, 16'h0000, ec, 1);
        offer(6'b011100, 16'h0010, ed, 1);
        offer(6'b111111, 16'h0000, ee, 1);
        scramble();
        check("drop_b2b", drop_count, NBITS * CPB);
        check("invalid_b2b", invalid_count, 2);
        wait_idle("idle_after_b2b");

        // Reset during DATA with a second result waiting in the buffer.
        offer(6'b101101, 16'h0000, ea, 1);
        offer(6'b000001, 16'hFFFF, eb, 0);
        scramble();
        repeat (6) step();
        check("busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_frame_done", frame_done, 0);
        check("abort_invalid_count", invalid_count, 0);
        check("abort_drop_count", drop_count, 0);
        repeat (10) step();
        check("rst_hold_tx", tx, 1);
        check("rst_hold_busy", busy, 0);
        rst = 1'b0; in_valid = 1'b1; alsu_out = 6'b101101; alsu_leds = 16'h0000;
        step();
        check("resume_accept", in_ready, 0);
        sb.push_back(ea);
        scramble();
        wait_idle("idle_after_resume");

        // Continuous in_valid: drops saturate while accepted frames keep flowing.
        acc = 0;
        alsu_out = 6'b000001; alsu_leds = 16'hFFFF; in_valid = 1'b1;
        for (int i = 0; i < 320; i++) begin
            rdy = in_ready;
            step();
            if (rdy) begin
                sb.push_back(mk(6'b000001, 1'b1, 1'b0, acc > 0));
                acc++;
            end
        end
        scramble();
        $display("[TB] saturation run: %0d accepted, drop_count=%0d", acc, drop_count);
        check("drop_saturated", drop_count, 255);
        check("invalid_after_sat", invalid_count, acc);
        wait_idle("idle_after_sat");

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
